icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 The block SHALL have parameter NUM_SETS, default 8, meaning number of direct-mapped lines (power of two, 2..64).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port mem_read  input  1  fetch request from the CPU instruction port, held high until mem_resp.
REQ-005 The block SHALL have port mem_address  input  32  byte address of the requested instruction word, held stable while mem_read is high.
REQ-006 The block SHALL have port mem_resp  output  1  one-cycle acknowledge; mem_rdata valid in that cycle.
REQ-007 The block SHALL have port mem_rdata  output  32  instruction word.
REQ-008 The block SHALL have port pmem_read  output  1  line-fill request to physical memory.
REQ-009 The block SHALL have port pmem_address  output  32  line-aligned fill address, bits [4:0] zero.
REQ-010 The block SHALL have port pmem_resp  input  1  one-cycle fill-complete strobe.
REQ-011 The block SHALL have port pmem_rdata  input  256  fill line, word k in bits [32k+31:32k].
REQ-012 The block SHALL, when ICACHE_STATS_EN is defined, have ports hit_count  output  32 and miss_count  output  32.

Function
REQ-013 The block SHALL decode addresses as offset [4:0], word select [4:2], index [4+log2(NUM_SETS):5], tag = remaining upper bits.
REQ-014 The block SHALL store per set one valid bit, one tag, and one 256-bit line.
REQ-015 The block SHALL implement states IDLE and FILL.
REQ-016 The block SHALL, in IDLE with mem_read high, valid set and tag match, assert mem_resp combinationally in the same cycle with mem_rdata = selected word (hit latency 0 cycles).
REQ-017 The block SHALL, in IDLE with mem_read high and a miss, transition to FILL at the next edge without asserting mem_resp.
REQ-018 The block SHALL, in FILL, drive pmem_read high and pmem_address = {mem_address[31:5], 5'b0} every cycle until pmem_resp.
REQ-019 The block SHALL, on pmem_resp in FILL, write pmem_rdata, tag and valid=1 into the indexed set and return to IDLE; the retried lookup hits the following cycle (miss latency = memory latency + 2 cycles).
REQ-020 The block SHALL NOT assert mem_resp in FILL and SHALL NOT forward pmem_rdata directly to mem_rdata.
REQ-021 The block SHALL ignore pmem_resp in IDLE.
REQ-022 The block SHALL keep pmem_read low in IDLE and mem_resp low whenever mem_read is low.
REQ-023 The block SHALL, on a fill to an occupied set, overwrite the previous line unconditionally (read-only cache, no writeback).
REQ-024 The block SHALL drive mem_rdata to 0 whenever mem_resp is low.

Reset
REQ-025 The block SHALL, on reset, clear all valid bits, enter IDLE, and drive mem_resp=0, pmem_read=0, pmem_address=0, mem_rdata=0.
REQ-026 The block SHALL, on reset asserted during FILL, abandon the fill, write no line, and ignore any later pmem_resp for it.
REQ-027 The block SHALL give reset priority over pmem_resp in the same cycle.

Configuration
REQ-028 The block SHALL, with ICACHE_STATS_EN defined, count each hit-response cycle in hit_count and each IDLE->FILL transition in miss_count, both reset to 0 and saturating at 32'hFFFFFFFF.
REQ-029 The block SHALL, without ICACHE_STATS_EN, omit hit_count, miss_count and their counters entirely.

Verification
REQ-030 Cold read 0x00000104 after reset, memory responds 3 cycles after pmem_read -> pmem_address=0x00000100, mem_resp high 5 cycles after request with word 1 of line.
REQ-031 Back-to-back reads 0x104 then 0x108 after fill -> both mem_resp in request cycle, no pmem_read.
REQ-032 NUM_SETS=8: read 0x00000000 then 0x00000100 (same index, different tag) then 0x00000000 -> three fills, stats miss_count=3, hit_count=3.
REQ-033 Reset asserted in 2nd FILL cycle, pmem_resp next cycle -> no line written; re-read of same address misses again.
REQ-034 pmem_resp pulsed while IDLE and mem_read low -> no state change, mem_resp stays 0, all valid bits unchanged.

Source files
------------

// File: rtl/icache_dm_if.sv
// Bus bundle between the CPU fetch port, the icache, and physical memory.
// The cache takes the slave view; the environment (CPU + memory) the master view.
interface icache_dm_if;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  modport master (
    output mem_read, mem_address, pmem_resp, pmem_rdata,
    input  mem_resp, mem_rdata, pmem_read, pmem_address
  );

  modport slave (
    input  mem_read, mem_address, pmem_resp, pmem_rdata,
    output mem_resp, mem_rdata, pmem_read, pmem_address
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with 32-byte lines and 0-cycle hits.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm #(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic        clk,
  input  logic        reset,
  icache_dm_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 32 - 5 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tags  [NUM_SETS];
  logic [255:0]        lines [NUM_SETS];
  logic                pmem_read_q;
  logic [31:0]         pmem_addr_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [2:0]          wsel;
  logic                tag_match;
  logic                hit;
  logic                miss;
  logic                fill_done;
  logic                unused_addr;

  assign wsel        = bus.mem_address[4:2];
  assign idx         = bus.mem_address[5 +: IDX_W];
  assign tag         = bus.mem_address[31 -: TAG_W];
  assign unused_addr = &{1'b0, bus.mem_address[1:0]};

  // Lookup is purely combinational so a hit answers in the request cycle.
  assign tag_match = valid[idx] && (tags[idx] == tag);
  assign hit       = !reset && (state == IDLE) && bus.mem_read && tag_match;
  assign miss      = !reset && (state == IDLE) && bus.mem_read && !tag_match;
  assign fill_done = !reset && (state == FILL) && bus.pmem_resp;

  assign bus.mem_resp     = hit;
  assign bus.mem_rdata    = hit ? lines[idx][{wsel, 5'b00000} +: 32] : 32'd0;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_address = pmem_addr_q;

  // Control FSM; reset outranks a coincident fill strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      pmem_read_q <= 1'b0;
      pmem_addr_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state       <= FILL;
            pmem_read_q <= 1'b1;
            pmem_addr_q <= {bus.mem_address[31:5], 5'b00000};
          end
        end
        FILL: begin
          if (bus.pmem_resp) begin
            state       <= IDLE;
            pmem_read_q <= 1'b0;
            pmem_addr_q <= 32'd0;
            valid[idx]  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays need no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      lines[idx] <= bus.pmem_rdata;
      tags[idx]  <= tag;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (miss && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: random fetches against a resident-line model
// and a deterministic backing memory; stats checked when ICACHE_STATS_EN is set.
module tb_icache_dm;
  localparam int unsigned NUM_SETS = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_dm_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_dm #(.NUM_SETS(NUM_SETS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q [$];
  logic [26:0] resident [int];
  int unsigned model_hits   = 0;
  int unsigned model_misses = 0;

  int          lat_cfg    = 3;
  bit          mem_en     = 1'b1;
  bit          inject     = 1'b0;
  int          fills_seen = 0;
  int          resp_cnt   = 0;
  logic [31:0] cur_line   = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Backing memory: every word is a fixed scramble of its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(la + 32'(4 * k));
    return l;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 5) % NUM_SETS);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = set_of(a);
    return resident.exists(s) && (resident[s] == a[31:5]);
  endfunction

  task automatic model_reset();
    resident.delete();
    model_hits   = 0;
    model_misses = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Physical memory: answers lat_cfg cycles after pmem_read first rises; random junk otherwise.
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      for (int k = 0; k < 8; k++) bus.pmem_rdata[32*k +: 32] = $urandom;
      if (inject) begin
        bus.pmem_resp = 1'b1;
      end else if (mem_en && bus.pmem_read) begin
        resp_cnt++;
        if (resp_cnt == 1) begin
          fills_seen++;
          check("pmem_address", bus.pmem_address, cur_line);
        end
        if (resp_cnt == lat_cfg + 1) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_line(bus.pmem_address);
          resp_cnt       = 0;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Monitor: every response pops the scoreboard; idle cycles must show zero data.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        if (exp_q.size() == 0) check("resp_without_request", 32'(bus.mem_resp), 32'd0);
        else                   check("mem_rdata", bus.mem_rdata, exp_q.pop_front());
      end else begin
        check("rdata_zero_when_idle", bus.mem_rdata, 32'd0);
      end
    end
  end

  // One fetch: push the expected word, hold the request, check hit/miss latency.
  task automatic do_read(input logic [31:0] addr, input bit keep);
    bit hit;
    bit got;
    int c;
    hit = model_hit(addr);
    exp_q.push_back(mem_word(addr));
    cur_line = {addr[31:5], 5'b00000};
    if (hit) model_hits++;
    else begin
      model_misses++;
      model_hits++;
    end
    bus.mem_read    = 1'b1;
    bus.mem_address = addr;
    got = 1'b0;
    c   = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        got = 1'b1;
        break;
      end
      c++;
    end
    if (!got) begin
      check("resp_timeout", 32'(bus.mem_resp), 32'd1);
      exp_q.delete();
    end else begin
      check(hit ? "hit_latency" : "miss_latency", 32'(c), hit ? 32'd0 : 32'(lat_cfg + 2));
    end
    resident[set_of(addr)] = addr[31:5];
    @(posedge clk);
    #1;
    if (!keep) bus.mem_read = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.mem_read = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    model_reset();
  endtask

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, 32'(model_hits));
    check("miss_count", miss_count, 32'(model_misses));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int f0;
    logic [31:0] a;
    reset           = 1'b1;
    bus.mem_read    = 1'b0;
    bus.mem_address = 32'd0;
    idle(2);
    check("reset_mem_resp", 32'(bus.mem_resp), 32'd0);
    check("reset_pmem_read", 32'(bus.pmem_read), 32'd0);
    check("reset_pmem_address", bus.pmem_address, 32'd0);
    check("reset_mem_rdata", bus.mem_rdata, 32'd0);
    reset = 1'b0;
    idle(1);
    model_reset();

    // Cold miss on 0x104 with 3-cycle memory.
    lat_cfg = 3;
    do_read(32'h0000_0104, 1'b0);

    // Back-to-back hits in the filled line.
    f0 = fills_seen;
    do_read(32'h0000_0104, 1'b1);
    do_read(32'h0000_0108, 1'b0);
    check("no_fill_on_hits", 32'(fills_seen), 32'(f0));

    // Stray pmem_resp while idle must not touch the cache.
    idle(1);
    inject = 1'b1;
    idle(1);
    inject = 1'b0;
    idle(1);
    check("stray_resp_pmem_read", 32'(bus.pmem_read), 32'd0);
    f0 = fills_seen;
    do_read(32'h0000_0100, 1'b0);
    check("stray_resp_still_valid", 32'(fills_seen), 32'(f0));
    do_read(32'h0000_0504, 1'b0);
    check_stats();

    // Conflict misses in one set.
    do_reset();
    f0 = fills_seen;
    do_read(32'h0000_0000, 1'b0);
    do_read(32'h0000_0100, 1'b0);
    do_read(32'h0000_0000, 1'b0);
    check("conflict_fills", 32'(fills_seen - f0), 32'd3);
    check_stats();

    // Reset in the second FILL cycle, fill strobes during and after reset.
    a      = 32'h0000_0344;
    mem_en = 1'b0;
    bus.mem_read    = 1'b1;
    bus.mem_address = a;
    idle(1);
    check("abort_pmem_read", 32'(bus.pmem_read), 32'd1);
    check("abort_pmem_address", bus.pmem_address, 32'h0000_0340);
    idle(1);
    reset        = 1'b1;
    inject       = 1'b1;
    bus.mem_read = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(1);
    inject = 1'b0;
    check("abort_pmem_read_low", 32'(bus.pmem_read), 32'd0);
    model_reset();
    mem_en  = 1'b1;
    lat_cfg = 2;
    do_read(a, 1'b0);
    check_stats();

    // Random fetch stream over a few tags per set, varying memory latency.
    for (int i = 0; i < 300; i++) begin
      lat_cfg = int'($urandom_range(1, 5));
      a = (32'($urandom_range(0, 95)) << 5) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
      do_read(a, 1'($urandom_range(0, 1)));
      if (bus.mem_read == 1'b0) idle(int'($urandom_range(0, 2)));
    end
    bus.mem_read = 1'b0;
    idle(3);
    check_stats();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
